// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master.
// Holds the controller state encoding and the AXI response codes.
package axil_pkg;

  // Controller states; at most one AXI transaction is ever in flight.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    RSP    = 3'd5
  } state_e;

  // AXI response codes, passed through to the command side unmodified.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_*                       command request (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                       response (valid/ready, write, rdata, resp)
//   m_axil_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                  state_q;
  logic                    cmd_ready_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    rready_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  // Handshake decodes; a channel counts as done once its valid has dropped or fires now.
  logic aw_fire_c;
  logic w_fire_c;
  logic aw_done_c;
  logic w_done_c;

  assign aw_fire_c = awvalid_q & m_axil_awready;
  assign w_fire_c  = wvalid_q & m_axil_wready;
  assign aw_done_c = ~awvalid_q | aw_fire_c;
  assign w_done_c  = ~wvalid_q | w_fire_c;

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end else begin
            // Covers the first cycle out of reset as well as the return from RSP.
            cmd_ready_q <= 1'b1;
          end
        end

        WR_REQ: begin
          if (aw_fire_c) awvalid_q <= 1'b0;
          if (w_fire_c)  wvalid_q  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q <= 1'b1;
            state_q  <= WR_RSP;
          end
        end

        WR_RSP: begin
          if (m_axil_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axil_bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RD_REQ: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_RSP;
          end
        end

        RD_RSP: begin
          if (m_axil_rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= m_axil_rresp;
            rsp_rdata_q <= m_axil_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: AXI slave model with per-channel
// stall knobs, directed cycle checks, and a response scoreboard.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_cmd_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
    .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave model knobs: cycles a valid waits before ready, response data.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0, rsp_lat = 0;
  logic        b_force = 1'b0;
  logic [1:0]  b_resp_val = 2'b00, r_resp_val = 2'b00;
  logic [31:0] r_data_val = 32'h0;

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  // AXI slave and response sink, updated just after each rising edge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, rs_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; rs_cnt = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
    rvalid = 0; rdata = 0; rresp = 0; rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_lat); ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_lat); b_cnt++; end
      else begin bvalid = 0; b_cnt = 0; end
      if (b_force) bvalid = 1'b1;
      bresp = b_resp_val;
      if (rready) begin rvalid = (r_cnt >= r_lat); r_cnt++; end
      else begin rvalid = 0; r_cnt = 0; end
      rdata = r_data_val;
      rresp = r_resp_val;
      if (rsp_valid) begin rsp_ready = (rs_cnt >= rsp_lat); rs_cnt++; end
      else begin rsp_ready = 0; rs_cnt = 0; end
    end
  end

  // Scoreboard: every response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_write", 64'(rsp_write), 64'(e.w));
        check_eq("sb_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check_eq("sb_resp",  64'(rsp_resp),  64'(e.resp));
      end
    end
  end

  // Presents one command; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    e.w = w; e.rdata = er; e.resp = eresp;
    exp_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    check_eq("accept", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    cmd_write = 1'($urandom);
  endtask

  // Waits for all expected responses and a return to IDLE.
  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || !cmd_ready) && n < 100);
    check_eq(tag, 64'(exp_q.size() == 0 && cmd_ready), 64'd1);
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    check_eq("rst_data", 64'({awaddr, wdata, rsp_rdata, rsp_resp}), 64'd0);
    check_eq("prot", 64'({awprot, arprot}), 64'd0);
    rst_n = 1;
    @(negedge clk);
    check_eq("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

    // Minimum-latency write.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    @(negedge clk);
    check_eq("w1_valids_t1", 64'({awvalid, wvalid, bready}), 64'b110);
    check_eq("w1_awaddr", 64'(awaddr), 64'h10);
    check_eq("w1_wdata", 64'({wdata, wstrb}), 64'({32'hDEADBEEF, 4'hF}));
    @(negedge clk);
    check_eq("w1_valids_t2", 64'({awvalid, wvalid, bready, rsp_valid}), 64'b0010);
    @(negedge clk);
    check_eq("w1_rsp_valid_t3", 64'({rsp_valid, cmd_ready}), 64'b10);
    @(negedge clk);
    check_eq("w1_idle_t4", 64'({rsp_valid, cmd_ready}), 64'b01);

    // Write with W stalled four cycles past AW; SLVERR passes through.
    w_lat = 4; b_resp_val = 2'b10;
    issue(1'b1, 32'h44, 32'h0BADF00D, 4'h3, 32'h0, 2'b10);
    @(negedge clk);
    check_eq("w2_valids_t1", 64'({awvalid, wvalid, bready}), 64'b110);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check_eq("w2_w_stall", 64'({awvalid, wvalid, bready}), 64'b010);
      check_eq("w2_wdata_stable", 64'({wdata, wstrb}), 64'({32'h0BADF00D, 4'h3}));
    end
    @(negedge clk);
    check_eq("w2_bready", 64'({awvalid, wvalid, bready}), 64'b001);
    drain("w2_drain");
    w_lat = 0; b_resp_val = 2'b00;

    // Read with AR stalled three cycles, SLVERR on R.
    ar_lat = 3; r_data_val = 32'h12345678; r_resp_val = 2'b10;
    issue(1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h12345678, 2'b10);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_eq("r1_ar_stall", 64'({arvalid, rready, awvalid, wvalid}), 64'b1000);
      check_eq("r1_araddr_stable", 64'(araddr), 64'h20);
    end
    @(negedge clk);
    check_eq("r1_rready", 64'({arvalid, rready}), 64'b01);
    @(negedge clk);
    check_eq("r1_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
             64'({1'b1, 1'b0, 2'b10, 32'h12345678}));
    drain("r1_drain");
    ar_lat = 0;

    // Response back-pressure: payload held, no new command accepted.
    rsp_lat = 5; r_data_val = 32'hCAFEF00D; r_resp_val = 2'b00;
    issue(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 3; i <= 8; i++) begin
      @(negedge clk);
      check_eq("bp_hold", 64'({rsp_valid, cmd_ready, rsp_resp, rsp_rdata}),
               64'({1'b1, 1'b0, 2'b00, 32'hCAFEF00D}));
    end
    @(negedge clk);
    check_eq("bp_release", 64'({rsp_valid, cmd_ready}), 64'b01);
    rsp_lat = 0;

    // Reset while AW/W are pending abandons the transaction.
    aw_lat = 3; w_lat = 3;
    issue(1'b1, 32'h50, 32'h55555555, 4'hF, 32'h0, 2'b00);
    @(negedge clk);
    check_eq("rr_pending", 64'({awvalid, wvalid}), 64'b11);
    rst_n = 0;
    @(negedge clk);
    void'(exp_q.pop_back());
    check_eq("rr_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}), 64'd0);
    check_eq("rr_data", 64'(awaddr), 64'd0);
    rst_n = 1;
    aw_lat = 0; w_lat = 0;
    @(negedge clk);
    check_eq("rr_cmd_ready", 64'(cmd_ready), 64'd1);
    issue(1'b1, 32'h80, 32'hA0A0A0A0, 4'h5, 32'h0, 2'b01);
    b_resp_val = 2'b01;
    drain("rr_next_drain");
    b_resp_val = 2'b00;

    // Spurious bvalid while idle is ignored.
    b_force = 1'b1; b_resp_val = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("spur_b", 64'({bready, cmd_ready, rsp_valid}), 64'b010);
    end
    b_force = 1'b0; b_resp_val = 2'b00;

    // DECERR read after the spurious beat.
    r_data_val = 32'hA5A50001; r_resp_val = 2'b11;
    issue(1'b0, 32'h90, 32'h0, 4'h0, 32'hA5A50001, 2'b11);
    drain("final_drain");

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 DATA_WIDTH, 32, data bus width in bits.
REQ-002 ADDR_WIDTH, 32, address width in bits.
REQ-003 STRB_WIDTH, DATA_WIDTH/8, write strobe width.
REQ-004 PROT, 3'b000, constant driven on m_axil_awprot and m_axil_arprot.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accept.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data, ignored for reads.
REQ-012 cmd_wstrb  input  STRB_WIDTH  write strobes, ignored for reads.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_write  output  1  copy of accepted cmd_write.
REQ-016 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-017 rsp_resp  output  2  captured bresp or rresp.
REQ-018 AW: m_axil_awaddr out ADDR_WIDTH, m_axil_awprot out 3, m_axil_awvalid out 1, m_axil_awready in 1.
REQ-019 W: m_axil_wdata out DATA_WIDTH, m_axil_wstrb out STRB_WIDTH, m_axil_wvalid out 1, m_axil_wready in 1.
REQ-020 B: m_axil_bresp in 2, m_axil_bvalid in 1, m_axil_bready out 1.
REQ-021 AR: m_axil_araddr out ADDR_WIDTH, m_axil_arprot out 3, m_axil_arvalid out 1, m_axil_arready in 1.
REQ-022 R: m_axil_rdata in DATA_WIDTH, m_axil_rresp in 2, m_axil_rvalid in 1, m_axil_rready out 1.

Function
REQ-023 FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP; at most one transaction outstanding.
REQ-024 cmd_ready is registered and is 1 only in IDLE; accept = cmd_valid && cmd_ready; addr/wdata/wstrb/write are captured on accept.
REQ-025 Write accept at cycle T: m_axil_awvalid and m_axil_wvalid both 1 from T+1; state WR_REQ.
REQ-026 Each of awvalid/wvalid drops the cycle after its own handshake; independent order; same-cycle handshakes allowed.
REQ-027 WR_REQ -> WR_RSP the cycle after both AW and W are done; m_axil_bready is 1 only in WR_RSP.
REQ-028 WR_RSP: on bvalid, capture bresp, rsp_rdata = 0 -> RSP.
REQ-029 Read accept at T: m_axil_arvalid 1 from T+1 (RD_REQ); on arready -> RD_RSP with m_axil_rready 1.
REQ-030 RD_RSP: on rvalid, capture rdata and rresp -> RSP.
REQ-031 RSP: rsp_valid 1 with stable payload until rsp_ready; then IDLE, and cmd_ready reasserts the next cycle.
REQ-032 Minimum latency: accept T, AXI handshake T+1, response handshake T+2, rsp_valid T+3.
REQ-033 AXI valid and payload held stable while valid && !ready; valid never drops before its handshake.
REQ-034 bvalid or rvalid outside WR_RSP/RD_RSP is ignored; bready/rready stay 0.
REQ-035 SLVERR/DECERR responses are passed through unmodified; no retry.

Reset
REQ-036 With rst_n = 0 at a clock edge: state IDLE; cmd_ready, rsp_valid, all m_axil_*valid, bready, rready = 0; all data/addr/resp outputs = 0.
REQ-037 cmd_ready rises the first cycle after rst_n returns to 1.
REQ-038 Reset mid-transaction abandons it: valids drop, no rsp_valid is produced for it.

Structure
REQ-039 Shared package axil_pkg holds the FSM state enum and resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-040 Single flat module; no sub-module.

Verification
REQ-041 Write 0x10/0xDEADBEEF/0xF, awready and wready 1, bvalid at T+2 bresp 0 -> rsp_valid T+3, rsp_resp 0, rsp_write 1.
REQ-042 Write with wready delayed 4 cycles after awready -> awvalid drops after 1 cycle, wvalid holds, bready only after W done.
REQ-043 Read 0x20, arready stalled 3 cycles, rdata 0x12345678 rresp 2 -> araddr stable, rsp_rdata 0x12345678, rsp_resp 2.
REQ-044 rsp_ready held 0 for 5 cycles -> rsp_valid and payload stable, cmd_ready 0 throughout.
REQ-045 rst_n low during WR_REQ -> next cycle all valids 0, no response; the following command completes normally.
REQ-046 Spurious bvalid in IDLE -> bready 0, state unchanged.
